// File: rtl/bitblade_slice_sched.sv
// Slice sequencer for the BitBlade 2-bit-slice dot-product datapath: walks
// (act slice, weight slice) passes and accumulates shifted partial sums.
module bitblade_slice_sched #(
    parameter int DOT_W = 10,
    parameter int ACC_W = 26
) (
    input  logic                    i_CLK,
    input  logic                    i_RSTn,
    input  logic                    i_start,
    input  logic [1:0]              i_prec_act,
    input  logic [1:0]              i_prec_w,
    input  logic                    i_signed_act,
    input  logic                    i_signed_w,
    input  logic                    i_op_valid,
    input  logic                    i_abort,
    input  logic signed [DOT_W-1:0] i_dot_sum,
    output logic [1:0]              o_act_slice,
    output logic [1:0]              o_w_slice,
    output logic                    o_SignI,
    output logic                    o_SignW,
    output logic                    o_busy,
    output logic                    o_valid,
    output logic signed [ACC_W-1:0] o_acc
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              act_q, act_d;
    logic [1:0]              w_q, w_d;
    logic [1:0]              na_last_q, na_last_d;
    logic [1:0]              nw_last_q, nw_last_d;
    logic                    sgn_a_q, sgn_a_d;
    logic                    sgn_w_q, sgn_w_d;
    logic                    busy_q, busy_d;
    logic                    valid_q, valid_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]              shamt;
    logic                    last_act, last_w;

    // Precision code to index of the MSB slice; code 3 is treated as 8b.
    function automatic logic [1:0] last_slice(input logic [1:0] prec);
        case (prec)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic signed [ACC_W-1:0] shifted_term(
        input logic signed [DOT_W-1:0] dot,
        input logic [3:0]              sh
    );
        logic signed [ACC_W-1:0] ext;
        ext = {{(ACC_W-DOT_W){dot[DOT_W-1]}}, dot};
        return ext <<< sh;
    endfunction

    assign last_act = (act_q == na_last_q);
    assign last_w   = (w_q == nw_last_q);
    assign shamt    = 4'({act_q, 1'b0}) + 4'({w_q, 1'b0});

    always_comb begin
        state_d   = state_q;
        act_d     = act_q;
        w_d       = w_q;
        na_last_d = na_last_q;
        nw_last_d = nw_last_q;
        sgn_a_d   = sgn_a_q;
        sgn_w_d   = sgn_w_q;
        acc_d     = acc_q;
        valid_d   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (i_start && !i_abort) begin
                    state_d   = RUN;
                    na_last_d = last_slice(i_prec_act);
                    nw_last_d = last_slice(i_prec_w);
                    sgn_a_d   = i_signed_act;
                    sgn_w_d   = i_signed_w;
                    acc_d     = '0;
                    act_d     = 2'd0;
                    w_d       = 2'd0;
                end
            end
            RUN: begin
                if (i_abort) begin
                    state_d = IDLE;
                    act_d   = 2'd0;
                    w_d     = 2'd0;
                end else if (i_op_valid) begin
                    acc_d = acc_q + shifted_term(i_dot_sum, shamt);
                    // Weight index is the inner loop; act advances when it wraps.
                    if (last_w) begin
                        w_d = 2'd0;
                        if (last_act) begin
                            act_d   = 2'd0;
                            state_d = DONE;
                            valid_d = 1'b1;
                        end else begin
                            act_d = act_q + 2'd1;
                        end
                    end else begin
                        w_d = w_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q   <= IDLE;
            act_q     <= 2'd0;
            w_q       <= 2'd0;
            na_last_q <= 2'd0;
            nw_last_q <= 2'd0;
            sgn_a_q   <= 1'b0;
            sgn_w_q   <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            w_q       <= w_d;
            na_last_q <= na_last_d;
            nw_last_q <= nw_last_d;
            sgn_a_q   <= sgn_a_d;
            sgn_w_q   <= sgn_w_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            acc_q     <= acc_d;
        end
    end

    // Only the MSB slice of a signed operand is presented as signed.
    assign o_SignI     = busy_q & sgn_a_q & last_act;
    assign o_SignW     = busy_q & sgn_w_q & last_w;
    assign o_act_slice = act_q;
    assign o_w_slice   = w_q;
    assign o_busy      = busy_q;
    assign o_valid     = valid_q;
    assign o_acc       = acc_q;

endmodule

// File: tb/tb_bitblade_slice_sched.sv
// Directed bench for bitblade_slice_sched: stimulus pushes expected results
// into a queue, a negedge monitor pops and compares on every o_valid.
module tb_bitblade_slice_sched;

    logic              clk = 1'b0;
    logic              i_RSTn;
    logic              i_start;
    logic [1:0]        i_prec_act;
    logic [1:0]        i_prec_w;
    logic              i_signed_act;
    logic              i_signed_w;
    logic              i_op_valid;
    logic              i_abort;
    logic signed [9:0] i_dot_sum;
    logic [1:0]        o_act_slice;
    logic [1:0]        o_w_slice;
    logic              o_SignI;
    logic              o_SignW;
    logic              o_busy;
    logic              o_valid;
    logic signed [25:0] o_acc;

    typedef struct {
        longint acc;
        int     cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    bitblade_slice_sched #(.DOT_W(10), .ACC_W(26)) dut (
        .i_CLK        (clk),
        .i_RSTn       (i_RSTn),
        .i_start      (i_start),
        .i_prec_act   (i_prec_act),
        .i_prec_w     (i_prec_w),
        .i_signed_act (i_signed_act),
        .i_signed_w   (i_signed_w),
        .i_op_valid   (i_op_valid),
        .i_abort      (i_abort),
        .i_dot_sum    (i_dot_sum),
        .o_act_slice  (o_act_slice),
        .o_w_slice    (o_w_slice),
        .o_SignI      (o_SignI),
        .o_SignW      (o_SignW),
        .o_busy       (o_busy),
        .o_valid      (o_valid),
        .o_acc        (o_acc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every result strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got o_valid=1 at cycle %0d, expected no result", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result_acc", longint'(o_acc), e.acc);
                check("result_cycle", longint'(cyc), longint'(e.cyc));
                check("busy_in_valid_cycle", longint'(o_busy), 0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the o_valid cycle so that a
    // following call starts the next job back-to-back.
    task automatic run_job(input logic [1:0] pa, input logic [1:0] pw,
                           input logic sa, input logic sw, input int dot,
                           input int passes, input logic [31:0] stall_mask,
                           input int extra_start, input logic [63:0] idx_seq,
                           input logic [31:0] sgn_seq, input longint exp_acc);
        int   p;
        int   total;
        int   start_cyc;
        exp_t e;
        logic [6:0] got;
        logic [6:0] want;
        p = 0;
        total = 0;
        while (p < passes) begin
            total++;
            if (!stall_mask[total]) p++;
        end
        i_start = 1'b1; i_prec_act = pa; i_prec_w = pw;
        i_signed_act = sa; i_signed_w = sw; i_op_valid = 1'b0;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        start_cyc = cyc;
        e.acc = exp_acc;
        e.cyc = start_cyc + total;
        q.push_back(e);
        p = 0;
        for (int k = 1; k <= total; k++) begin
            i_op_valid = !stall_mask[k];
            i_dot_sum  = 10'(dot);
            i_start    = (k == extra_start);
            @(negedge clk);
            got  = {o_busy, o_act_slice, o_w_slice, o_SignI, o_SignW};
            want = {1'b1, idx_seq[4*p +: 4], sgn_seq[2*p +: 2]};
            check("pass_busy_idx_sign", longint'(got), longint'(want));
            if (!stall_mask[k]) p++;
            @(posedge clk);
            #1;
        end
        i_op_valid = 1'b0;
        i_start    = 1'b0;
    endtask

    initial begin
        i_RSTn = 1'b0; i_start = 1'b0; i_prec_act = 2'd0; i_prec_w = 2'd0;
        i_signed_act = 1'b0; i_signed_w = 1'b0; i_op_valid = 1'b0;
        i_abort = 1'b0; i_dot_sum = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl_outputs",
              longint'({o_act_slice, o_w_slice, o_SignI, o_SignW, o_busy, o_valid}), 0);
        check("reset_acc", longint'(o_acc), 0);
        @(posedge clk);
        #1;
        i_RSTn = 1'b1;
        idle(2);

        // Reset asserted during pass 2 of an 8bx8b job.
        i_start = 1'b1; i_prec_act = 2'd2; i_prec_w = 2'd2;
        i_signed_act = 1'b0; i_signed_w = 1'b0;
        @(posedge clk);
        #1;
        i_start = 1'b0; i_op_valid = 1'b1; i_dot_sum = 10'sd1;
        @(posedge clk);
        #1;
        #2;
        i_RSTn = 1'b0;
        #1;
        check("midjob_reset_ctrl",
              longint'({o_act_slice, o_w_slice, o_SignI, o_SignW, o_busy, o_valid}), 0);
        check("midjob_reset_acc", longint'(o_acc), 0);
        @(posedge clk);
        #1;
        i_RSTn = 1'b1;
        i_op_valid = 1'b0;
        @(negedge clk);
        check("midjob_reset_idle", longint'(o_busy), 0);
        @(posedge clk);
        #1;
        idle(3);

        // 2bx2b signed, then 4bx4b signed started in the o_valid cycle.
        run_job(2'd0, 2'd0, 1'b1, 1'b1, -3, 1, 32'h0, 0, 64'h0, 32'h3, -3);
        run_job(2'd1, 2'd1, 1'b1, 1'b1, 1, 4, 32'h0, 0, 64'h5410, 32'hE4, 25);
        idle(2);

        // 8bx8b unsigned with stalls in cycles 3 and 7.
        run_job(2'd2, 2'd2, 1'b0, 1'b0, 1, 16, 32'h88, 0,
                64'hFEDCBA9876543210, 32'h0, 7225);
        idle(2);

        // Abort in RUN with a same-cycle start; then abort blocking a start in IDLE.
        i_start = 1'b1; i_prec_act = 2'd2; i_prec_w = 2'd0;
        i_signed_act = 1'b1; i_signed_w = 1'b0;
        @(posedge clk);
        #1;
        i_start = 1'b0; i_op_valid = 1'b1; i_dot_sum = 10'sd5;
        @(posedge clk);
        #1;
        i_abort = 1'b1; i_start = 1'b1;
        @(posedge clk);
        #1;
        i_abort = 1'b0; i_start = 1'b0; i_op_valid = 1'b0;
        @(negedge clk);
        check("abort_to_idle", longint'(o_busy), 0);
        check("abort_idx_cleared", longint'({o_act_slice, o_w_slice}), 0);
        @(posedge clk);
        #1;
        i_start = 1'b1; i_abort = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0; i_abort = 1'b0;
        @(negedge clk);
        check("abort_blocks_start", longint'(o_busy), 0);
        @(posedge clk);
        #1;
        run_job(2'd2, 2'd0, 1'b1, 1'b0, -1, 4, 32'h0, 0, 64'hC840, 32'h80, -85);
        idle(2);

        // Precision code 3 behaves as 8b; a start in cycle 5 is ignored.
        run_job(2'd3, 2'd3, 1'b1, 1'b1, 1, 16, 32'h0, 5,
                64'hFEDCBA9876543210, 32'hEA404040, 7225);
        idle(6);

        check("pending_results", longint'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
